// File: rtl/l3_adder_pkg.sv
// Shared types and defaults for the L3 adder sequencer and its result FIFO.
package l3_adder_pkg;

  localparam int DEF_DATA_WIDTH = 18;
  localparam int DEF_ARRAY_SIZE = 2;
  localparam int LANE_OUT_W     = DEF_DATA_WIDTH + 1;

  // Pairing state: either waiting for operand A or holding it for operand B.
  typedef enum logic {
    IDLE   = 1'b0,
    HAVE_A = 1'b1
  } state_t;

  // One entry of the issue tag pipeline that shadows the adder latency.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/l3_result_fifo.sv
// Synchronous FIFO that buffers adder results plus their window-last flag.
// Head entry is presented combinationally; DEPTH must be a power of two.
module l3_result_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot being written, so push while full is legal only alongside a pop.
  always_comb begin
    do_pop  = pop & (count != '0);
    do_push = push & ((count != CW'(DEPTH)) | do_pop);
  end

  // Storage, pointers and occupancy; reset empties the FIFO and clears stale contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/l3_adder_sequencer.sv
// Pairs packed partial-sum words from the L2 stage and issues them to the L3 adder array.
// A tag pipeline tracks results through the adder; issue is credit-gated so the result
// FIFO can always absorb every result that is in flight.
module l3_adder_sequencer
  import l3_adder_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ARRAY_SIZE  = DEF_ARRAY_SIZE,
  parameter int ADD_LATENCY = 1,
  parameter int OUT_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH*ARRAY_SIZE-1:0]   in_data,
  input  logic                               in_last,
  output logic                               add_enable,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0]   add_num_1,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0]   add_num_2,
  input  logic [(DATA_WIDTH+1)*ARRAY_SIZE-1:0] add_out_num,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [(DATA_WIDTH+1)*ARRAY_SIZE-1:0] out_data,
  output logic                               out_last,
  output logic                               busy
);

  localparam int IN_W   = DATA_WIDTH * ARRAY_SIZE;
  localparam int OUT_W  = (DATA_WIDTH + 1) * ARRAY_SIZE;
  localparam int FIFO_W = OUT_W + 1;
  localparam int CNT_W  = $clog2(OUT_DEPTH) + 1;
  localparam int PEND_W = $clog2(OUT_DEPTH + ADD_LATENCY + 2) + 1;

  state_t            state;
  logic [IN_W-1:0]   hold_a;
  tag_t              tag_pipe [ADD_LATENCY+1];

  logic              accept;
  logic              issue_fire;
  logic              credit_ok;
  logic [PEND_W-1:0] pending;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_push;
  logic [FIFO_W-1:0] fifo_head;

  // Results already buffered plus every issue still travelling through the adder.
  // Stage 0 of the tag pipeline is the issue currently presented to the array.
  always_comb begin
    pending = PEND_W'(fifo_count) + PEND_W'(tag_pipe[0].valid);
    for (int i = 1; i <= ADD_LATENCY; i++) begin
      pending = pending + PEND_W'(tag_pipe[i].valid);
    end
  end

  // Accept only while a FIFO slot is guaranteed for anything this word could issue.
  // An issue happens when the word completes a pair or closes a window on its own.
  always_comb begin
    credit_ok  = (pending < PEND_W'(OUT_DEPTH));
    accept     = in_valid & credit_ok;
    issue_fire = accept & ((state == HAVE_A) | in_last);
  end

  assign in_ready = credit_ok;

  // Pairing FSM with registered adder operands; add_enable is a one-cycle pulse per issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hold_a     <= '0;
      add_enable <= 1'b0;
      add_num_1  <= '0;
      add_num_2  <= '0;
    end else begin
      add_enable <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (in_last) begin
              add_num_1  <= in_data;
              add_num_2  <= '0;
              add_enable <= 1'b1;
            end else begin
              hold_a <= in_data;
              state  <= HAVE_A;
            end
          end
          HAVE_A: begin
            add_num_1  <= hold_a;
            add_num_2  <= in_data;
            add_enable <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Tag pipeline: the tail lines up with add_out_num becoming valid for that issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= ADD_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{valid: issue_fire, last: issue_fire & in_last};
      for (int i = 1; i <= ADD_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign fifo_push = tag_pipe[ADD_LATENCY].valid;

  l3_result_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (OUT_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({tag_pipe[ADD_LATENCY].last, add_out_num}),
    .pop       (out_ready),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_head[OUT_W-1:0];
  assign out_last  = fifo_head[OUT_W] & ~fifo_empty;
  assign busy      = (state == HAVE_A) | (pending != '0);

endmodule

// File: tb/tb_l3_adder_sequencer.sv
// Bench for l3_adder_sequencer together with a one-cycle L3 adder array model.
// Accepted words feed a pairing model that queues expected results; every popped
// result is compared against the head of that queue.
module tb_l3_adder_sequencer;

  localparam int DW = 18;
  localparam int AS = 2;
  localparam int LW = DW + 1;
  localparam int IW = DW * AS;
  localparam int OW = LW * AS;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          add_enable;
  logic [IW-1:0] add_num_1;
  logic [IW-1:0] add_num_2;
  logic [OW-1:0] add_out_num;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int            tests_run = 0;
  int            tests_failed = 0;
  int            cycle = 0;
  logic [OW:0]   sb [$];
  int            pop_cycle [$];
  logic [OW:0]   exp_e;
  logic [IW-1:0] m_hold;
  bit            m_have_a = 1'b0;
  bit            stuck = 1'b0;

  l3_adder_sequencer #(
    .DATA_WIDTH  (DW),
    .ARRAY_SIZE  (AS),
    .ADD_LATENCY (1),
    .OUT_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .add_enable  (add_enable),
    .add_num_1   (add_num_1),
    .add_num_2   (add_num_2),
    .add_out_num (add_out_num),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // L3 adder array: one registered unsigned add per lane, one cycle after add_enable.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_out_num <= '0;
    end else if (add_enable) begin
      for (int i = 0; i < AS; i++) begin
        add_out_num[i*LW +: LW] <= {1'b0, add_num_1[i*DW +: DW]} + {1'b0, add_num_2[i*DW +: DW]};
      end
    end
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Expected two-lane sum, widened so nothing wraps.
  function automatic logic [OW-1:0] exp_sum(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [LW-1:0] lo;
    logic [LW-1:0] hi;
    lo = LW'(a[DW-1:0]) + LW'(b[DW-1:0]);
    hi = LW'(a[IW-1:DW]) + LW'(b[IW-1:DW]);
    return {hi, lo};
  endfunction

  // Advance one cycle: sample handshakes mid-cycle, update the pairing model,
  // check any popped result against the scoreboard, then wait for the next negedge.
  task automatic tick();
    #2;
    if (!reset) begin
      sb.delete();
      m_have_a = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        if (m_have_a) begin
          sb.push_back({in_last, exp_sum(m_hold, in_data)});
          m_have_a = 1'b0;
        end else if (in_last) begin
          sb.push_back({1'b1, exp_sum(in_data, '0)});
        end else begin
          m_hold   = in_data;
          m_have_a = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        pop_cycle.push_back(cycle);
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL sb_unexpected: got %h, no result was expected", {out_last, out_data});
        end else begin
          exp_e = sb.pop_front();
          if ({out_last, out_data} !== exp_e) begin
            tests_failed++;
            $display("[TB] FAIL sb_result: got %h expected %h", {out_last, out_data}, exp_e);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [IW-1:0] d, input logic l);
    bit done;
    done     = 1'b0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      done = in_ready;
      tick();
    end
    if (!done) stuck = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int c = 0; c < budget && !out_valid; c++) tick();
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    tests_run++;
    if ({add_enable, out_valid, out_last, busy} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {add_enable, out_valid, out_last, busy});
    end
    tests_run++;
    if ({add_num_1, add_num_2} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_operands: got %h expected 0", {add_num_1, add_num_2});
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_pair_basic();
    send_word({18'h00005, 18'h00003}, 1'b0);
    send_word({18'h00007, 18'h00001}, 1'b1);
    tests_run++;
    if ({add_enable, add_num_1, add_num_2} !== {1'b1, 18'h00005, 18'h00003, 18'h00007, 18'h00001}) begin
      tests_failed++;
      $display("[TB] FAIL pair_issue: got %h expected %h", {add_enable, add_num_1, add_num_2},
               {1'b1, 18'h00005, 18'h00003, 18'h00007, 18'h00001});
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL pair_latency_0: out_valid got %b expected 0", out_valid);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL pair_latency_1: out_valid got %b expected 0", out_valid);
    end
    tick();
    tests_run++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 19'h0000C, 19'h00004}) begin
      tests_failed++;
      $display("[TB] FAIL pair_result: got %h expected %h", {out_valid, out_last, out_data},
               {1'b1, 1'b1, 19'h0000C, 19'h00004});
    end
    wait_drain(20);
  endtask

  task automatic test_zero_pad();
    send_word({18'h3FFFF, 18'h3FFFF}, 1'b1);
    tests_run++;
    if ({add_enable, add_num_2} !== {1'b1, 36'h0}) begin
      tests_failed++;
      $display("[TB] FAIL pad_operand_b: got %h expected %h", {add_enable, add_num_2}, {1'b1, 36'h0});
    end
    wait_valid(8);
    tests_run++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 19'h3FFFF, 19'h3FFFF}) begin
      tests_failed++;
      $display("[TB] FAIL pad_result: got %h expected %h", {out_valid, out_last, out_data},
               {1'b1, 1'b1, 19'h3FFFF, 19'h3FFFF});
    end
    wait_drain(20);
  endtask

  task automatic test_max_hold();
    send_word({18'h3FFFF, 18'h3FFFF}, 1'b0);
    repeat (5) tick();
    tests_run++;
    if ({busy, add_enable, out_valid} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL hold_idle: got %b expected 100", {busy, add_enable, out_valid});
    end
    send_word({18'h3FFFF, 18'h3FFFF}, 1'b1);
    wait_valid(8);
    tests_run++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 19'h7FFFE, 19'h7FFFE}) begin
      tests_failed++;
      $display("[TB] FAIL max_result: got %h expected %h", {out_valid, out_last, out_data},
               {1'b1, 1'b1, 19'h7FFFE, 19'h7FFFE});
    end
    wait_drain(20);
    tests_run++;
    if (stuck !== 1'b0 || sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL directed_drain: stuck=%b pending=%0d expected 0/0", stuck, sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] w [12];
    int  sent;
    int  stall;
    int  at_stall;
    int  pops_before;
    bit  fire;
    for (int i = 0; i < 12; i++) w[i] = {18'($urandom), 18'($urandom)};
    sent        = 0;
    stall       = 0;
    at_stall    = -1;
    pops_before = pop_cycle.size();
    out_ready   = 1'b0;
    for (int c = 0; c < 400 && sent < 12; c++) begin
      in_valid = 1'b1;
      in_data  = w[sent];
      in_last  = (sent == 11);
      fire     = in_ready;
      tick();
      if (fire) begin
        sent++;
        stall = 0;
      end else begin
        stall++;
      end
      if (stall == 12 && at_stall < 0) begin
        at_stall = sent;
        tests_run++;
        if (at_stall != 8) begin
          tests_failed++;
          $display("[TB] FAIL bp_accepts_before_stall: got %0d expected 8", at_stall);
        end
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b011) begin
          tests_failed++;
          $display("[TB] FAIL bp_stalled_flags: got %b expected 011", {in_ready, out_valid, busy});
        end
        tests_run++;
        if (pop_cycle.size() != pops_before) begin
          tests_failed++;
          $display("[TB] FAIL bp_no_early_pop: got %0d pops expected 0", pop_cycle.size() - pops_before);
        end
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    wait_drain(60);
    tests_run++;
    if (sent != 12 || pop_cycle.size() - pops_before != 6) begin
      tests_failed++;
      $display("[TB] FAIL bp_delivered: sent %0d results %0d expected 12/6", sent,
               pop_cycle.size() - pops_before);
    end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] w [8];
    int  sent;
    int  cycles;
    int  ae_high;
    int  first_pop;
    bit  ae_prev;
    bit  ae_double;
    bit  fire;
    for (int i = 0; i < 8; i++) w[i] = {18'($urandom), 18'($urandom)};
    sent      = 0;
    cycles    = 0;
    ae_high   = 0;
    ae_prev   = 1'b0;
    ae_double = 1'b0;
    first_pop = pop_cycle.size();
    out_ready = 1'b1;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      in_valid = 1'b1;
      in_data  = w[sent];
      in_last  = (sent == 7);
      fire     = in_ready;
      if (add_enable) begin
        ae_high++;
        if (ae_prev) ae_double = 1'b1;
      end
      ae_prev = add_enable;
      tick();
      cycles++;
      if (fire) sent++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) begin
      if (add_enable) begin
        ae_high++;
        if (ae_prev) ae_double = 1'b1;
      end
      ae_prev = add_enable;
      tick();
    end
    tests_run++;
    if (cycles != 8) begin
      tests_failed++;
      $display("[TB] FAIL b2b_no_stall: took %0d cycles expected 8", cycles);
    end
    tests_run++;
    if (ae_high != 4 || ae_double) begin
      tests_failed++;
      $display("[TB] FAIL b2b_enable_pulses: got %0d pulses double=%b expected 4/0", ae_high, ae_double);
    end
    wait_drain(30);
    tests_run++;
    if (pop_cycle.size() - first_pop != 4) begin
      tests_failed++;
      $display("[TB] FAIL b2b_result_count: got %0d expected 4", pop_cycle.size() - first_pop);
    end
    for (int i = first_pop + 1; i < pop_cycle.size(); i++) begin
      tests_run++;
      if (pop_cycle[i] - pop_cycle[i-1] != 2) begin
        tests_failed++;
        $display("[TB] FAIL b2b_interval: got %0d cycles expected 2", pop_cycle[i] - pop_cycle[i-1]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int seen;
    int first_pop;
    out_ready = 1'b1;
    send_word({18'h00011, 18'h00022}, 1'b0);
    send_word({18'h00033, 18'h00044}, 1'b0);
    send_word({18'h00055, 18'h00066}, 1'b0);
    reset = 1'b0;
    tick();
    tests_run++;
    if ({out_valid, busy, add_enable} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL rst_flight_clear: got %b expected 000", {out_valid, busy, add_enable});
    end
    reset     = 1'b1;
    seen      = 0;
    first_pop = pop_cycle.size();
    repeat (10) begin
      if (out_valid) seen++;
      tick();
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("[TB] FAIL rst_no_ghost: out_valid high %0d cycles expected 0", seen);
    end
    send_word({18'h00100, 18'h00200}, 1'b0);
    send_word({18'h00001, 18'h00002}, 1'b1);
    wait_drain(20);
    tests_run++;
    if (pop_cycle.size() - first_pop != 1 || stuck !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_recover: got %0d results stuck=%b expected 1/0",
               pop_cycle.size() - first_pop, stuck);
    end
  endtask

  initial begin
    test_reset();
    test_pair_basic();
    test_zero_pad();
    test_max_hold();
    test_backpressure();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
